// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the instruction loader: address/instruction widths,
// the largest loadable program, the byte layout of one instruction word and
// the loader state encoding.
// -----------------------------------------------------------------------------
package loader_pkg;

  localparam int ADDR_W         = 11;    // instruction-memory word address width
  localparam int INST_W         = 33;    // instruction word width
  localparam int MAX_WORDS      = 2048;  // largest program, in words
  localparam int LEN_W          = 16;    // width of the length header
  localparam int BYTES_PER_WORD = 5;     // bytes on the wire per instruction word

  // Index of the final byte of a word within the 5-byte group.
  localparam logic [2:0] LAST_BYTE_IDX = 3'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_LO  = 3'd1,
    LEN_HI  = 3'd2,
    BYTE    = 3'd3,
    WRITE   = 3'd4,
    RELEASE = 3'd5,
    ERR     = 3'd6
  } state_t;

  // A length header is loadable when it names between 1 and MAX_WORDS words.
  // Zero is legal too, but it performs no writes and is handled separately.
  function automatic logic len_too_big(input logic [LEN_W-1:0] len);
    return len > LEN_W'(MAX_WORDS);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Steers a little-endian 5-byte group into one 33-bit instruction word.
// Bytes 0..3 fill data[31:0]; bit 0 of byte 4 becomes data[32], the other
// seven bits of byte 4 are dropped.
//
// Ports
//   clock      : rising-edge clock
//   reset      : synchronous, active-high
//   clear      : restart at byte 0 (used before the first word of a load)
//   byte_en    : a byte is being accepted this cycle
//   byte_in    : the byte being accepted
//   word       : assembled word; complete and stable while word_ready is 1
//   last_byte  : the next accepted byte completes the word
//   word_ready : one-cycle pulse on the cycle after the fifth byte is taken
// -----------------------------------------------------------------------------
module word_assembler
  import loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic [INST_W-1:0] word,
  output logic              last_byte,
  output logic              word_ready
);

  logic [2:0] byte_idx;

  assign last_byte = (byte_idx == LAST_BYTE_IDX);

  // NOTE: non-blocking assignments throughout, so every register in this
  // block samples the values that existed before the clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_idx   <= '0;
      word       <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= 1'b0;
      if (clear) begin
        byte_idx <= '0;
      end else if (byte_en) begin
        case (byte_idx)
          3'd0:    word[7:0]   <= byte_in;
          3'd1:    word[15:8]  <= byte_in;
          3'd2:    word[23:16] <= byte_in;
          3'd3:    word[31:24] <= byte_in;
          default: word[32]    <= byte_in[0];
        endcase
        if (last_byte) begin
          byte_idx   <= '0;
          word_ready <= 1'b1;
        end else begin
          byte_idx <= byte_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
// Loads a program into instruction memory from a byte stream while the CPU
// is frozen. Stream format: a 16-bit little-endian word count, then 5 bytes
// per instruction word. A zero count releases the CPU without writing; a
// count above MAX_WORDS parks the loader in ERR until reset.
//
// Ports
//   clock     : rising-edge clock
//   reset     : synchronous, active-high; aborts any load in progress
//   start     : pulse in IDLE that begins a load (ignored elsewhere)
//   rx_data   : load byte stream
//   rx_valid  : rx_data qualifier
//   rx_ready  : loader can take a byte (transfer when valid & ready)
//   mem_we    : one-cycle instruction-memory write strobe
//   mem_addr  : instruction-memory word address (valid while mem_we)
//   mem_data  : instruction word (valid while mem_we)
//   cpu_hold  : freezes fetch for the whole load
//   cpu_flush : one-cycle pulse flushing IF after the load
//   done      : sticky load-complete flag, cleared by the next start
//   error     : sticky bad-length flag, cleared only by reset
// -----------------------------------------------------------------------------
module inst_loader
  import loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [INST_W-1:0] mem_data,
  output logic              cpu_hold,
  output logic              cpu_flush,
  output logic              done,
  output logic              error
);

  state_t             state;
  logic [7:0]         len_lo;
  logic [ADDR_W-1:0]  word_idx;
  logic [ADDR_W-1:0]  last_idx;   // index of the final word of this load
  logic [LEN_W-1:0]   len_now;
  logic               accept;
  logic               asm_last;

  assign accept  = rx_valid && rx_ready;
  assign len_now = {rx_data, len_lo};

  // The assembler holds the finished word in its own register, so mem_data
  // and mem_we come straight from it: the word cannot change during WRITE
  // because rx_ready is low there.
  word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (state == LEN_HI),
    .byte_en    (accept && (state == BYTE)),
    .byte_in    (rx_data),
    .word       (mem_data),
    .last_byte  (asm_last),
    .word_ready (mem_we)
  );

  // Outputs are registered alongside the state: each transition sets the
  // values the destination state must present.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      len_lo    <= '0;
      word_idx  <= '0;
      last_idx  <= '0;
      rx_ready  <= 1'b0;
      mem_addr  <= '0;
      cpu_hold  <= 1'b0;
      cpu_flush <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      cpu_flush <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= LEN_LO;
            done     <= 1'b0;
            rx_ready <= 1'b1;
            cpu_hold <= 1'b1;
          end
        end

        LEN_LO: begin
          if (accept) begin
            len_lo <= rx_data;
            state  <= LEN_HI;
          end
        end

        LEN_HI: begin
          if (accept) begin
            if (len_now == '0) begin
              state     <= RELEASE;
              rx_ready  <= 1'b0;
              cpu_flush <= 1'b1;
            end else if (len_too_big(len_now)) begin
              // The only guard keeping addresses inside 0..MAX_WORDS-1.
              state    <= ERR;
              rx_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state    <= BYTE;
              word_idx <= '0;
              last_idx <= ADDR_W'(len_now - LEN_W'(1));
            end
          end
        end

        BYTE: begin
          if (accept && asm_last) begin
            state    <= WRITE;
            rx_ready <= 1'b0;
            mem_addr <= word_idx;
          end
        end

        WRITE: begin
          if (word_idx == last_idx) begin
            state     <= RELEASE;
            cpu_flush <= 1'b1;
          end else begin
            state    <= BYTE;
            word_idx <= word_idx + ADDR_W'(1);
            rx_ready <= 1'b1;
          end
        end

        RELEASE: begin
          state    <= IDLE;
          done     <= 1'b1;
          cpu_hold <= 1'b0;
        end

        ERR: begin
          // Parked with hold and error asserted until reset.
        end

        default: begin
          state    <= IDLE;
          rx_ready <= 1'b0;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_loader
// Scoreboarded bench for inst_loader. Expected memory writes are computed
// from the byte stream with plain arithmetic and queued; a monitor pops and
// compares on every mem_we, and also watches the flush/hold/done handshake.
// -----------------------------------------------------------------------------
module tb_inst_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [32:0] mem_data;
  logic        cpu_hold;
  logic        cpu_flush;
  logic        done;
  logic        error;

  always #5 clock = ~clock;

  inst_loader dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .cpu_hold  (cpu_hold),
    .cpu_flush (cpu_flush),
    .done      (done),
    .error     (error)
  );

  typedef struct {
    int          addr;
    logic [32:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks    = 0;
  int  n_pass      = 0;
  int  flush_count = 0;
  logic prev_flush = 1'b0;

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Reference word: little-endian, only bit 0 of the fifth byte is kept.
  function automatic logic [32:0] model_word(input logic [7:0] b0, b1, b2, b3, b4);
    logic [63:0] v;
    v = 64'(b0) + 64'(b1) * 64'd256 + 64'(b2) * 64'd65536 +
        64'(b3) * (64'd1 << 24) + 64'(b4 % 2) * (64'd1 << 32);
    return v[32:0];
  endfunction

  // Monitor: scoreboard pops on writes, plus flush/hold/done sequencing.
  always @(negedge clock) begin
    if (reset) begin
      prev_flush = 1'b0;
    end else begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(mem_we), 64'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_addr", 64'(mem_addr), 64'(e.addr));
          check("write_data", 64'(mem_data), 64'(e.data));
        end
      end
      if (cpu_flush) begin
        flush_count++;
        check("hold_during_flush", 64'(cpu_hold), 64'd1);
      end
      if (prev_flush) begin
        check("hold_after_flush", 64'(cpu_hold), 64'd0);
        check("done_after_flush", 64'(done), 64'd1);
        check("flush_one_cycle", 64'(cpu_flush), 64'd0);
      end
      prev_flush = cpu_flush;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
    check({tag, "_mem_we"},   64'(mem_we),   64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_data"}, 64'(mem_data), 64'd0);
    check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
    check({tag, "_cpu_flush"},64'(cpu_flush),64'd0);
    check({tag, "_done"},     64'(done),     64'd0);
    check({tag, "_error"},    64'(error),    64'd0);
  endtask

  task automatic do_reset(input string tag);
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clock);
    check_all_zero(tag);
    reset = 1'b0;
  endtask

  task automatic pulse_start(input bit expect_idle);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (expect_idle) begin
      check("done_cleared_by_start", 64'(done), 64'd0);
      check("hold_after_start", 64'(cpu_hold), 64'd1);
    end
  endtask

  // Present one byte after 'gap' idle cycles; wait (bounded) for the transfer.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit taken;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
    taken    = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (rx_ready) begin
        @(negedge clock);
        taken = 1'b1;
        break;
      end
      @(negedge clock);
    end
    rx_valid = 1'b0;
    if (!taken) check("rx_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int flush_before);
    for (int n = 0; n < 100; n++) begin
      if (done) break;
      @(negedge clock);
    end
    check("done_set", 64'(done), 64'd1);
    check("all_writes_seen", 64'(exp_q.size()), 64'd0);
    check("one_flush", 64'(flush_count - flush_before), 64'd1);
    check("no_error", 64'(error), 64'd0);
    check("hold_released", 64'(cpu_hold), 64'd0);
    check("ready_low_idle", 64'(rx_ready), 64'd0);
  endtask

  // Full load: length header + words. Expected writes come from the stream.
  task automatic load_bytes(input logic [7:0] stream[$], input int gap,
                            input int inject_start_at);
    int len;
    int f0;
    len = int'(stream[0]) + 256 * int'(stream[1]);
    if (len > 0 && len <= 2048) begin
      for (int i = 0; i < len; i++) begin
        wr_t e;
        e.addr = i;
        e.data = model_word(stream[2+5*i], stream[3+5*i], stream[4+5*i],
                            stream[5+5*i], stream[6+5*i]);
        exp_q.push_back(e);
      end
    end
    f0 = flush_count;
    pulse_start(1'b1);
    for (int k = 0; k < stream.size(); k++) begin
      if (k == inject_start_at) pulse_start(1'b0);
      send_byte(stream[k], gap);
    end
    wait_done(f0);
  endtask

  initial begin
    logic [7:0] s[$];
    int f0;
    int nw;

    do_reset("reset");

    // Two-word directed load.
    s = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h01,
          8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    load_bytes(s, 0, -1);

    // Zero-length load: flush only.
    s = '{8'h00, 8'h00};
    load_bytes(s, 0, -1);

    // Gapped stream with byte4 = FF.
    s = '{8'h01, 8'h00, 8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'hFF};
    load_bytes(s, 3, -1);

    // Start pulsed mid-word must be ignored.
    s = '{8'h01, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFE};
    load_bytes(s, 0, 4);

    // Reset after three data bytes, then a clean one-word load.
    pulse_start(1'b1);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h99, 0);
    send_byte(8'h88, 0);
    send_byte(8'h77, 0);
    do_reset("midload_reset");
    s = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h02};
    load_bytes(s, 0, -1);

    // Randomized loads.
    for (int r = 0; r < 8; r++) begin
      nw = int'($urandom_range(1, 5));
      s = {};
      s.push_back(8'(nw));
      s.push_back(8'h00);
      for (int i = 0; i < 5 * nw; i++) s.push_back(8'($urandom_range(0, 255)));
      load_bytes(s, int'($urandom_range(0, 2)), -1);
    end

    // Maximum legal length: last write must land at 2047.
    s = {};
    s.push_back(8'h00);
    s.push_back(8'h08);
    for (int i = 0; i < 5 * 2048; i++) s.push_back(8'($urandom_range(0, 255)));
    load_bytes(s, 0, -1);

    // Length 2049: error, hold stays, no writes, start ignored.
    f0 = flush_count;
    pulse_start(1'b1);
    send_byte(8'h01, 0);
    send_byte(8'h08, 0);
    repeat (20) @(negedge clock);
    check("err_error", 64'(error), 64'd1);
    check("err_hold", 64'(cpu_hold), 64'd1);
    check("err_ready", 64'(rx_ready), 64'd0);
    check("err_done", 64'(done), 64'd0);
    pulse_start(1'b0);
    repeat (5) @(negedge clock);
    check("err_sticky", 64'(error), 64'd1);
    check("err_hold_sticky", 64'(cpu_hold), 64'd1);
    check("err_ready_after_start", 64'(rx_ready), 64'd0);
    check("err_no_flush", 64'(flush_count - f0), 64'd0);
    do_reset("err_reset");
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
